zvc_pack_ctrl: RTL and testbench

- Zero-value compaction controller for the redundancy-controller datapath.
- Accepts 32-word lines and uses a combinational LFPrefixAdder32 instance on the per-word nonzero mask to get each surviving word's destination slot.
- Packs nonzero words densely into a double-line buffer and emits full packed lines over a valid/ready stream.
- Sequences end-of-tensor flush and publishes the per-line bitmask on a side channel for the metadata writer.

---
 rtl/zvc_pack_ctrl.sv | 103 ++++++++++
 tb/tb_zvc_pack_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zvc_pack_ctrl.sv
// zvc_pack_ctrl: zero-value compaction of 32-word lines into a dense packed output stream.
// Also holds LFPrefixAdder32, the mask prefix network that gives each surviving word its slot.
module LFPrefixAdder32 (
  input  logic [31:0]  i_bits,
  output logic [191:0] o_psum
);
  logic [5:0] w_s [32];
  // Ladner-Fischer (minimum depth) network: each level adds the last sum of the lower half-block
  always_comb begin
    for (int i = 0; i < 32; i++) w_s[i] = {5'd0, i_bits[i]};
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 32; i++)
        if (((i >> k) & 1) == 1) w_s[i] = w_s[i] + w_s[((i >> (k + 1)) << (k + 1)) + (1 << k) - 1];
    for (int i = 0; i < 32; i++) o_psum[i*6 +: 6] = w_s[i];
  end
endmodule

module zvc_pack_ctrl #(
  parameter int WORD_WIDTH = 8,
  parameter int LINE_SIZE  = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0] in_line,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LINE_SIZE*WORD_WIDTH-1:0] out_line,
  output logic [5:0]                      out_count,
  output logic                            out_last,
  output logic                            mask_valid,
  output logic [LINE_SIZE-1:0]            mask_out,
  output logic [5:0]                      mask_cnt
);
  if (LINE_SIZE != 32) begin : g_bad_size
    $error("zvc_pack_ctrl: LINE_SIZE must be 32");
  end
  typedef enum logic {RUN, FLUSH} state_t;
  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_buf [2*LINE_SIZE];
  logic [6:0]            r_fill;
  logic                  r_mask_valid;
  logic [LINE_SIZE-1:0]  r_mask;
  logic [5:0]            r_mask_cnt;
  logic [LINE_SIZE-1:0]  w_mask;
  logic [LINE_SIZE*6-1:0] w_psum;
  logic [5:0]            w_slot [LINE_SIZE];
  logic [5:0]            w_total;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_emit;
  for (genvar i = 0; i < LINE_SIZE; i++) begin : g_lane
    assign w_mask[i] = |in_line[i*WORD_WIDTH +: WORD_WIDTH];
    assign w_slot[i] = r_fill[5:0] + w_psum[i*6 +: 6] - 6'd1;
    assign out_line[i*WORD_WIDTH +: WORD_WIDTH] = r_buf[i];
  end
  LFPrefixAdder32 u_psum (
    .i_bits (w_mask),
    .o_psum (w_psum)
  );
  assign w_total    = w_psum[(LINE_SIZE-1)*6 +: 6];
  assign w_full     = r_fill >= 7'd32;
  assign in_ready   = (r_state == RUN) && !w_full;
  assign out_valid  = (r_state == FLUSH) || w_full;
  // slots at or above fill are always zero, so the lower half doubles as a zero-padded beat
  assign out_count  = w_full ? 6'd32 : (r_state == FLUSH) ? r_fill[5:0] : 6'd0;
  assign out_last   = (r_state == FLUSH) && (r_fill <= 7'd32);
  assign w_accept   = in_valid && in_ready;
  assign w_emit     = out_valid && out_ready;
  assign mask_valid = r_mask_valid;
  assign mask_out   = r_mask;
  assign mask_cnt   = r_mask_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RUN;
      r_fill       <= '0;
      r_mask_valid <= 1'b0;
      r_mask       <= '0;
      r_mask_cnt   <= '0;
      for (int j = 0; j < 2*LINE_SIZE; j++) r_buf[j] <= '0;
    end else begin
      r_mask_valid <= w_accept;
      if (w_emit) begin
        for (int j = 0; j < LINE_SIZE; j++) begin
          r_buf[j]           <= r_buf[j+LINE_SIZE];
          r_buf[j+LINE_SIZE] <= '0;
        end
        r_fill <= r_fill - {1'b0, out_count};
        if (out_last) r_state <= RUN;
      end
      if (w_accept) begin
        for (int i = 0; i < LINE_SIZE; i++)
          if (w_mask[i]) r_buf[w_slot[i]] <= in_line[i*WORD_WIDTH +: WORD_WIDTH];
        r_fill     <= r_fill + {1'b0, w_total};
        r_mask     <= w_mask;
        r_mask_cnt <= w_total;
        if (in_last) r_state <= FLUSH;
      end
    end
  end
endmodule

// File: tb/tb_zvc_pack_ctrl.sv
// tb_zvc_pack_ctrl: directed scenarios plus a long random-mask run for the compaction controller.
module tb_zvc_pack_ctrl;
  localparam int W = 8, N = 32, LW = W*N;
  typedef struct {logic [LW-1:0] line; logic [5:0] cnt; logic last; int cyc;} beat_t;
  logic clk = 0, reset_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid, out_last, mask_valid;
  logic [LW-1:0] in_line = '0, out_line;
  logic [5:0] out_count, mask_cnt;
  logic [N-1:0] mask_out;
  int vectors = 0, miscompares = 0, cycle = 0;
  beat_t beats[$];
  logic [N-1:0] masks[$];
  logic [5:0] mcnts[$];
  int acc_cyc[$];
  beat_t bt;

  always #5 clk = ~clk;

  zvc_pack_ctrl #(.WORD_WIDTH(W), .LINE_SIZE(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_line(in_line), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_line(out_line), .out_count(out_count), .out_last(out_last),
    .mask_valid(mask_valid), .mask_out(mask_out), .mask_cnt(mask_cnt)
  );

  // record handshakes and mask pulses as they happen
  always @(posedge clk) begin
    cycle++;
    if (reset_n && out_valid && out_ready) begin
      bt.line = out_line; bt.cnt = out_count; bt.last = out_last; bt.cyc = cycle;
      beats.push_back(bt);
    end
    if (reset_n && mask_valid) begin masks.push_back(mask_out); mcnts.push_back(mask_cnt); end
    if (reset_n && in_valid && in_ready) acc_cyc.push_back(cycle);
  end

  function automatic beat_t bt_at(int i);
    beat_t z;
    z.line = '0; z.cnt = '1; z.last = 1'bx; z.cyc = -1;
    return (i < beats.size()) ? beats[i] : z;
  endfunction
  function automatic logic [N-1:0] mask_at(int i);
    return (i < masks.size()) ? masks[i] : 'x;
  endfunction
  function automatic logic [5:0] mcnt_at(int i);
    return (i < mcnts.size()) ? mcnts[i] : 'x;
  endfunction
  function automatic int acc_at(int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -100;
  endfunction

  task automatic clear_logs();
    beats.delete(); masks.delete(); mcnts.delete(); acc_cyc.delete();
  endtask

  task automatic apply_reset();
    in_valid = 0; in_last = 0; in_line = '0; out_ready = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic send(input logic [LW-1:0] l, input logic last);
    int n = 0;
    in_valid = 1; in_line = l; in_last = last;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL send_wait in_ready=%0b want=1 after %0d cycles", in_ready, n); end
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_reset();
    in_valid = 0; in_last = 0; in_line = '0; out_ready = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    vectors++; if ({out_valid, out_last, mask_valid} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got=%b want=000", {out_valid, out_last, mask_valid}); end
    vectors++; if (out_line !== '0) begin miscompares++; $display("FAIL rst_out_line got=%h want=0", out_line); end
    vectors++; if ({out_count, mask_cnt} !== 12'd0) begin miscompares++; $display("FAIL rst_counts got=%0d/%0d want=0/0", out_count, mask_cnt); end
    vectors++; if (mask_out !== '0) begin miscompares++; $display("FAIL rst_mask_out got=%h want=0", mask_out); end
    reset_n = 1;
    @(negedge clk);
    vectors++; if ({in_ready, out_valid} !== 2'b10) begin miscompares++; $display("FAIL rst_release rdy/vld got=%b want=10", {in_ready, out_valid}); end
    clear_logs();
  endtask

  task automatic test_sparse();
    logic [LW-1:0] l, e0, e1;
    beat_t b;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      l[i*W +: W]  = (i % 2 == 0) ? W'(i + 1) : '0;
      e0[i*W +: W] = W'(2 * (i % 16) + 1);
      e1[i*W +: W] = (i < 16) ? W'(2 * i + 1) : '0;
    end
    out_ready = 1;
    send(l, 0);
    send(l, 0);
    vectors++; if ({in_ready, out_valid} !== 2'b01) begin miscompares++; $display("FAIL sp_full rdy/vld got=%b want=01", {in_ready, out_valid}); end
    send(l, 1);
    repeat (4) @(negedge clk);
    vectors++; if (beats.size() != 2) begin miscompares++; $display("FAIL sp_nbeats got=%0d want=2", beats.size()); end
    b = bt_at(0);
    vectors++; if (b.line !== e0) begin miscompares++; $display("FAIL sp_beat0_line got=%h want=%h", b.line, e0); end
    vectors++; if ({b.cnt, b.last} !== {6'd32, 1'b0}) begin miscompares++; $display("FAIL sp_beat0_cnt_last got=%0d/%b want=32/0", b.cnt, b.last); end
    b = bt_at(1);
    vectors++; if (b.line !== e1) begin miscompares++; $display("FAIL sp_flush_line got=%h want=%h", b.line, e1); end
    vectors++; if ({b.cnt, b.last} !== {6'd16, 1'b1}) begin miscompares++; $display("FAIL sp_flush_cnt_last got=%0d/%b want=16/1", b.cnt, b.last); end
    vectors++; if (acc_at(2) - acc_at(1) != 2) begin miscompares++; $display("FAIL sp_stall got=%0d cycles want=2", acc_at(2) - acc_at(1)); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({mask_at(k), mcnt_at(k)} !== {32'h55555555, 6'd16}) begin miscompares++; $display("FAIL sp_mask%0d got=%h/%0d want=55555555/16", k, mask_at(k), mcnt_at(k)); end
    end
    vectors++; if ({in_ready, out_valid} !== 2'b10) begin miscompares++; $display("FAIL sp_idle rdy/vld got=%b want=10", {in_ready, out_valid}); end
  endtask

  task automatic test_zero_line();
    beat_t b;
    apply_reset();
    out_ready = 1;
    send('0, 1);
    repeat (4) @(negedge clk);
    vectors++; if (masks.size() != 1) begin miscompares++; $display("FAIL zl_nmask got=%0d want=1", masks.size()); end
    vectors++; if ({mask_at(0), mcnt_at(0)} !== 38'd0) begin miscompares++; $display("FAIL zl_mask got=%h/%0d want=0/0", mask_at(0), mcnt_at(0)); end
    vectors++; if (beats.size() != 1) begin miscompares++; $display("FAIL zl_nbeats got=%0d want=1", beats.size()); end
    b = bt_at(0);
    vectors++; if ({b.line, b.cnt, b.last} !== {{LW{1'b0}}, 6'd0, 1'b1}) begin miscompares++; $display("FAIL zl_beat got=%h/%0d/%b want=0/0/1", b.line, b.cnt, b.last); end
    vectors++; if ({in_ready, out_valid} !== 2'b10) begin miscompares++; $display("FAIL zl_back_to_run got=%b want=10", {in_ready, out_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] ls [4];
    beat_t b;
    apply_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) ls[k][i*W +: W] = W'(i + 1 + 32 * k);
    out_ready = 1;
    for (int k = 0; k < 4; k++) send(ls[k], 0);
    repeat (4) @(negedge clk);
    vectors++; if (beats.size() != 4) begin miscompares++; $display("FAIL bb_nbeats got=%0d want=4", beats.size()); end
    for (int k = 0; k < 4; k++) begin
      b = bt_at(k);
      vectors++; if (b.line !== ls[k]) begin miscompares++; $display("FAIL bb_line%0d got=%h want=%h", k, b.line, ls[k]); end
      vectors++; if ({b.cnt, b.last} !== {6'd32, 1'b0}) begin miscompares++; $display("FAIL bb_cnt%0d got=%0d/%b want=32/0", k, b.cnt, b.last); end
      vectors++; if (b.cyc != acc_at(k) + 1) begin miscompares++; $display("FAIL bb_emit_cyc%0d got=%0d want=%0d", k, b.cyc, acc_at(k) + 1); end
      vectors++; if ({mask_at(k), mcnt_at(k)} !== {32'hFFFFFFFF, 6'd32}) begin miscompares++; $display("FAIL bb_mask%0d got=%h/%0d want=ffffffff/32", k, mask_at(k), mcnt_at(k)); end
    end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (acc_at(k + 1) != acc_at(k) + 2) begin miscompares++; $display("FAIL bb_acc_gap%0d got=%0d want=2", k, acc_at(k + 1) - acc_at(k)); end
    end
  endtask

  task automatic build_40(output logic [LW-1:0] a, output logic [LW-1:0] b, output logic [LW-1:0] e0, output logic [LW-1:0] e1);
    for (int i = 0; i < N; i++) begin
      a[i*W +: W]  = (i < 20) ? W'(8'h40 + i) : '0;
      b[i*W +: W]  = (i >= 12) ? W'(8'h80 + i) : '0;
      e0[i*W +: W] = (i < 20) ? W'(8'h40 + i) : W'(8'h8C + i - 20);
      e1[i*W +: W] = (i < 8) ? W'(8'h98 + i) : '0;
    end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] a, b, e0, e1;
    beat_t x;
    build_40(a, b, e0, e1);
    apply_reset();
    send(a, 0);
    send(b, 0);
    for (int c = 0; c < 5; c++) begin
      vectors++; if ({out_valid, in_ready, out_count} !== {2'b10, 6'd32}) begin miscompares++; $display("FAIL bp_hold%0d vld/rdy/cnt got=%b/%b/%0d want=1/0/32", c, out_valid, in_ready, out_count); end
      vectors++; if (out_line !== e0) begin miscompares++; $display("FAIL bp_line%0d got=%h want=%h", c, out_line, e0); end
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    vectors++; if ({in_ready, out_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_release rdy/vld got=%b want=10", {in_ready, out_valid}); end
    vectors++; if (bt_at(0).line !== e0 || beats.size() != 1) begin miscompares++; $display("FAIL bp_beat0 n=%0d got=%h want=%h", beats.size(), bt_at(0).line, e0); end
    out_ready = 1;
    send('0, 1);
    repeat (4) @(negedge clk);
    x = bt_at(1);
    vectors++; if ({x.line, x.cnt, x.last} !== {e1, 6'd8, 1'b1}) begin miscompares++; $display("FAIL bp_rest got=%h/%0d/%b want=%h/8/1", x.line, x.cnt, x.last, e1); end
  endtask

  task automatic test_reset_mid_flush();
    logic [LW-1:0] a, b, e0, e1, c, ec;
    beat_t x;
    build_40(a, b, e0, e1);
    apply_reset();
    send(a, 0);
    send(b, 1);
    vectors++; if ({out_valid, out_last} !== 2'b10) begin miscompares++; $display("FAIL rf_pre vld/last got=%b want=10", {out_valid, out_last}); end
    reset_n = 0;
    #1;
    vectors++; if ({in_ready, out_valid, out_last, mask_valid} !== 4'b1000) begin miscompares++; $display("FAIL rf_flags got=%b want=1000", {in_ready, out_valid, out_last, mask_valid}); end
    vectors++; if ({out_line, out_count, mask_out, mask_cnt} !== '0) begin miscompares++; $display("FAIL rf_data line=%h cnt=%0d mask=%h mcnt=%0d want all 0", out_line, out_count, mask_out, mask_cnt); end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    clear_logs();
    c = '0; ec = '0;
    for (int i = 0; i < 5; i++) begin
      c[(4 * i + 3)*W +: W] = W'(8'h11 + i);
      ec[i*W +: W] = W'(8'h11 + i);
    end
    out_ready = 1;
    send(c, 1);
    repeat (4) @(negedge clk);
    x = bt_at(0);
    vectors++; if (beats.size() != 1) begin miscompares++; $display("FAIL rf_nbeats got=%0d want=1", beats.size()); end
    vectors++; if ({x.line, x.cnt, x.last} !== {ec, 6'd5, 1'b1}) begin miscompares++; $display("FAIL rf_fresh got=%h/%0d/%b want=%h/5/1", x.line, x.cnt, x.last, ec); end
  endtask

  task automatic test_random();
    logic [7:0] exp_w[$], got_w[$];
    int exp_last[$], got_last[$];
    logic [N-1:0] exp_m[$];
    logic [LW-1:0] l;
    logic [N-1:0] m;
    logic [7:0] w;
    int sent = 0, cyc = 0, dens, bad_words = 0, bad_pad = 0, bad_last = 0, bad_mask = 0;
    logic acc, last;
    apply_reset();
    while (sent < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 7) != 0) begin
        dens = $urandom_range(0, 4);
        dens = (dens == 0) ? 0 : (dens == 1) ? 25 : (dens == 2) ? 50 : (dens == 3) ? 90 : 100;
        for (int i = 0; i < N; i++) begin
          w = ($urandom_range(1, 100) <= dens) ? 8'($urandom_range(1, 255)) : 8'd0;
          l[i*W +: W] = w;
          m[i] = (w != 0);
        end
        last = ($urandom_range(0, 15) == 0) || (sent == 999);
        in_line = l; in_last = last; in_valid = 1;
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) begin
        for (int i = 0; i < N; i++) if (m[i]) exp_w.push_back(l[i*W +: W]);
        exp_m.push_back(m);
        if (last) exp_last.push_back(exp_w.size());
        sent++;
        in_valid = 0; in_last = 0;
      end
    end
    in_valid = 0; out_ready = 1;
    repeat (10) @(negedge clk);
    vectors++; if (sent != 1000) begin miscompares++; $display("FAIL rnd_sent got=%0d want=1000", sent); end
    foreach (beats[k]) begin
      l = beats[k].line;
      for (int j = 0; j < N; j++) begin
        w = l[j*W +: W];
        if (j < int'(beats[k].cnt)) got_w.push_back(w);
        else if (w != 0) bad_pad++;
      end
      if (!beats[k].last && beats[k].cnt != 6'd32) bad_pad++;
      if (beats[k].last) got_last.push_back(got_w.size());
    end
    vectors++; if (got_w.size() != exp_w.size()) begin miscompares++; $display("FAIL rnd_nwords got=%0d want=%0d", got_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i >= got_w.size() || got_w[i] !== exp_w[i]) bad_words++;
    vectors++; if (bad_words != 0) begin miscompares++; $display("FAIL rnd_words wrong=%0d want=0", bad_words); end
    vectors++; if (bad_pad != 0) begin miscompares++; $display("FAIL rnd_padding bad=%0d want=0", bad_pad); end
    if (got_last.size() != exp_last.size()) bad_last++;
    foreach (exp_last[i]) if (i >= got_last.size() || got_last[i] != exp_last[i]) bad_last++;
    vectors++; if (bad_last != 0) begin miscompares++; $display("FAIL rnd_last_align bad=%0d got_n=%0d want_n=%0d", bad_last, got_last.size(), exp_last.size()); end
    if (masks.size() != exp_m.size()) bad_mask++;
    foreach (exp_m[i]) if (mask_at(i) !== exp_m[i] || mcnt_at(i) !== 6'($countones(exp_m[i]))) bad_mask++;
    vectors++; if (bad_mask != 0) begin miscompares++; $display("FAIL rnd_masks bad=%0d got_n=%0d want_n=%0d", bad_mask, masks.size(), exp_m.size()); end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_zero_line();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
